nv_nvdla_sdp_mcif_rd_arb: RTL and testbench

NV_NVDLA_SDP_MCIF_RD_ARB -- requirements
Module: nv_nvdla_sdp_mcif_rd_arb

---
 rtl/nv_nvdla_sdp_rd_arb_pkg.sv | 28 ++
 rtl/nv_nvdla_sdp_rd_tag_fifo.sv | 57 +++++
 rtl/nv_nvdla_sdp_mcif_rd_arb.sv | 115 +++++++++++
 tb/tb_nv_nvdla_sdp_mcif_rd_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nv_nvdla_sdp_rd_arb_pkg.sv
// Shared types and widths for the SDP MCIF read arbiter and its tag FIFO.
// A tag records which client issued a read and how many beats (size+1) it returns.
package nv_nvdla_sdp_rd_arb_pkg;

   localparam int RD_REQ_PD_W = 47;
   localparam int RD_RSP_PD_W = 65;
   localparam int SIZE_W      = 15;

   typedef enum logic [1:0] {
      CLT_MAIN = 2'd0,
      CLT_B    = 2'd1,
      CLT_N    = 2'd2
   } clt_id_e;

   typedef struct packed {
      clt_id_e             id;
      logic [SIZE_W-1:0]   size;
   } rd_tag_t;

   // (k + off) mod 3, valid for k, off in 0..2
   function automatic logic [1:0] rr_next(input logic [1:0] k, input logic [1:0] off);
      logic [2:0] s;
      s = {1'b0, k} + {1'b0, off};
      if (s >= 3'd3) s = s - 3'd3;
      return s[1:0];
   endfunction

endpackage

// File: rtl/nv_nvdla_sdp_rd_tag_fifo.sv
// Flop-based FIFO of outstanding read tags; push when full and pop when empty are ignored.
// The head entry is visible combinationally on rd_tag; there is no write-to-read bypass.
module nv_nvdla_sdp_rd_tag_fifo
   import nv_nvdla_sdp_rd_arb_pkg::*;
#(
   parameter int TAG_DEPTH = 8
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  rd_tag_t wr_tag,
   input  logic    pop,
   output rd_tag_t rd_tag,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(TAG_DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = TAG_DEPTH[AW:0];

   rd_tag_t         mem [TAG_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW:0]     count;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == CNT_MAX);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_tag  = mem[rd_ptr];

   // Pointers wrap naturally because TAG_DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_tag;
   end

endmodule

// File: rtl/nv_nvdla_sdp_mcif_rd_arb.sv
// Round-robin arbiter merging three SDP read clients onto one MCIF read port, with
// in-order response routing driven by a FIFO of {client, size} tags.
module nv_nvdla_sdp_mcif_rd_arb
   import nv_nvdla_sdp_rd_arb_pkg::*;
#(
   parameter int TAG_DEPTH = 8,
   parameter int NCLIENT   = 3
) (
   input  logic                                   nvdla_core_clk,
   input  logic                                   nvdla_core_rst,
   input  logic [NCLIENT-1:0]                     clt_rd_req_valid,
   output logic [NCLIENT-1:0]                     clt_rd_req_ready,
   input  logic [NCLIENT-1:0][RD_REQ_PD_W-1:0]    clt_rd_req_pd,
   output logic                                   mcif_rd_req_valid,
   input  logic                                   mcif_rd_req_ready,
   output logic [RD_REQ_PD_W-1:0]                 mcif_rd_req_pd,
   input  logic                                   mcif_rd_rsp_valid,
   output logic                                   mcif_rd_rsp_ready,
   input  logic [RD_RSP_PD_W-1:0]                 mcif_rd_rsp_pd,
   output logic [NCLIENT-1:0]                     clt_rd_rsp_valid,
   input  logic [NCLIENT-1:0]                     clt_rd_rsp_ready,
   output logic [RD_RSP_PD_W-1:0]                 clt_rd_rsp_pd,
   output logic [NCLIENT-1:0]                     clt_rd_cdt_lat_fifo_pop,
   output logic                                   rsp_err
);

   localparam logic [NCLIENT-1:0] ONE_HOT0 = 1;

   logic [1:0]        rr_ptr;
   logic              gnt_found;
   clt_id_e           gnt_id;
   logic              can_grant;
   logic              grant;
   rd_tag_t           push_tag;
   rd_tag_t           head_tag;
   logic              tag_full;
   logic              tag_empty;
   logic              beat_acc;
   logic              last_beat;
   logic [SIZE_W-1:0] beat_cnt;

   // First requesting client at or after rr_ptr wins
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = CLT_MAIN;
      for (int i = 0; i < 3; i++) begin
         if (!gnt_found && clt_rd_req_valid[rr_next(rr_ptr, 2'(i))]) begin
            gnt_found = 1'b1;
            gnt_id    = clt_id_e'(rr_next(rr_ptr, 2'(i)));
         end
      end
   end

   // A pop in this cycle never frees a slot for a push in the same cycle
   assign can_grant        = (!mcif_rd_req_valid || mcif_rd_req_ready) && !tag_full;
   assign grant            = gnt_found && can_grant && !nvdla_core_rst;
   assign clt_rd_req_ready = grant ? (ONE_HOT0 << gnt_id) : '0;

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         mcif_rd_req_valid <= 1'b0;
         mcif_rd_req_pd    <= '0;
         rr_ptr            <= 2'd0;
      end else if (grant) begin
         mcif_rd_req_valid <= 1'b1;
         mcif_rd_req_pd    <= clt_rd_req_pd[gnt_id];
         rr_ptr            <= rr_next(gnt_id, 2'd1);
      end else if (mcif_rd_req_ready) begin
         mcif_rd_req_valid <= 1'b0;
      end
   end

   assign push_tag.id   = gnt_id;
   assign push_tag.size = clt_rd_req_pd[gnt_id][RD_REQ_PD_W-1:32];

   nv_nvdla_sdp_rd_tag_fifo #(
      .TAG_DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .clk    (nvdla_core_clk),
      .rst    (nvdla_core_rst),
      .push   (grant),
      .wr_tag (push_tag),
      .pop    (last_beat),
      .rd_tag (head_tag),
      .full   (tag_full),
      .empty  (tag_empty)
   );

   // With no outstanding tag the beat is swallowed and flagged
   always_comb begin
      clt_rd_rsp_valid  = '0;
      mcif_rd_rsp_ready = 1'b1;
      if (!tag_empty) begin
         clt_rd_rsp_valid  = mcif_rd_rsp_valid ? (ONE_HOT0 << head_tag.id) : '0;
         mcif_rd_rsp_ready = clt_rd_rsp_ready[head_tag.id];
      end
   end

   assign clt_rd_rsp_pd           = mcif_rd_rsp_pd;
   assign clt_rd_cdt_lat_fifo_pop = clt_rd_rsp_valid & clt_rd_rsp_ready;
   assign beat_acc                = !tag_empty && mcif_rd_rsp_valid && mcif_rd_rsp_ready;
   assign last_beat               = beat_acc && (beat_cnt == head_tag.size);

   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         beat_cnt <= '0;
         rsp_err  <= 1'b0;
      end else begin
         if (last_beat)     beat_cnt <= '0;
         else if (beat_acc) beat_cnt <= beat_cnt + 1'b1;
         if (mcif_rd_rsp_valid && tag_empty) rsp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_nv_nvdla_sdp_mcif_rd_arb.sv
// Bench for the SDP MCIF read arbiter: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference model of grants and responses.
module tb_nv_nvdla_sdp_mcif_rd_arb;
   import nv_nvdla_sdp_rd_arb_pkg::*;

   localparam int DEPTH = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [2:0]                    clt_rd_req_valid;
   logic [2:0]                    clt_rd_req_ready;
   logic [2:0][RD_REQ_PD_W-1:0]   clt_rd_req_pd;
   logic                          mcif_rd_req_valid;
   logic                          mcif_rd_req_ready;
   logic [RD_REQ_PD_W-1:0]        mcif_rd_req_pd;
   logic                          mcif_rd_rsp_valid;
   logic                          mcif_rd_rsp_ready;
   logic [RD_RSP_PD_W-1:0]        mcif_rd_rsp_pd;
   logic [2:0]                    clt_rd_rsp_valid;
   logic [2:0]                    clt_rd_rsp_ready;
   logic [RD_RSP_PD_W-1:0]        clt_rd_rsp_pd;
   logic [2:0]                    clt_rd_cdt_lat_fifo_pop;
   logic                          rsp_err;

   nv_nvdla_sdp_mcif_rd_arb #(.TAG_DEPTH(DEPTH), .NCLIENT(3)) dut (
      .nvdla_core_clk          (clk),
      .nvdla_core_rst          (rst),
      .clt_rd_req_valid        (clt_rd_req_valid),
      .clt_rd_req_ready        (clt_rd_req_ready),
      .clt_rd_req_pd           (clt_rd_req_pd),
      .mcif_rd_req_valid       (mcif_rd_req_valid),
      .mcif_rd_req_ready       (mcif_rd_req_ready),
      .mcif_rd_req_pd          (mcif_rd_req_pd),
      .mcif_rd_rsp_valid       (mcif_rd_rsp_valid),
      .mcif_rd_rsp_ready       (mcif_rd_rsp_ready),
      .mcif_rd_rsp_pd          (mcif_rd_rsp_pd),
      .clt_rd_rsp_valid        (clt_rd_rsp_valid),
      .clt_rd_rsp_ready        (clt_rd_rsp_ready),
      .clt_rd_rsp_pd           (clt_rd_rsp_pd),
      .clt_rd_cdt_lat_fifo_pop (clt_rd_cdt_lat_fifo_pop),
      .rsp_err                 (rsp_err)
   );

   // ---------------- scoreboard / reference model ----------------
   int n_vec = 0;
   int n_err = 0;
   logic [16:0]            exp_q[$];   // outstanding reads: {client, size}
   int                     m_rr;
   bit                     m_out_v;
   logic [RD_REQ_PD_W-1:0] m_out_pd;
   int                     m_beats;
   bit                     m_err;
   int                     gnt_log[$];
   int                     cdt_cnt[3];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      exp_q.delete();
      m_rr     = 0;
      m_out_v  = 0;
      m_out_pd = '0;
      m_beats  = 0;
      m_err    = 0;
   endfunction

   // One clock: compare at negedge, advance model at posedge, return 1 after it
   task automatic cycle();
      int         w;
      int         c;
      int         hid;
      bit         can;
      logic [2:0] e_rdy;
      logic [2:0] e_rv;
      logic       e_rsp_rdy;
      @(negedge clk);
      if (rst) model_reset();
      w = -1;
      for (int i = 0; i < 3; i++) begin
         c = (m_rr + i) % 3;
         if (w < 0 && clt_rd_req_valid[c]) w = c;
      end
      can = !rst && (!m_out_v || mcif_rd_req_ready) && (exp_q.size() < DEPTH);
      if (!can) w = -1;
      e_rdy = (w >= 0) ? 3'(1 << w) : 3'b000;
      e_rv  = 3'b000;
      e_rsp_rdy = 1'b1;
      if (exp_q.size() > 0) begin
         hid       = int'(exp_q[0][16:15]);
         e_rv      = mcif_rd_rsp_valid ? 3'(1 << hid) : 3'b000;
         e_rsp_rdy = clt_rd_rsp_ready[hid];
      end
      check("req_ready",      clt_rd_req_ready, e_rdy);
      check("mcif_req_valid", mcif_rd_req_valid, m_out_v);
      check("mcif_req_pd",    mcif_rd_req_pd, m_out_pd);
      check("rsp_valid",      clt_rd_rsp_valid, e_rv);
      check("mcif_rsp_ready", mcif_rd_rsp_ready, e_rsp_rdy);
      check("rsp_pd",         clt_rd_rsp_pd, mcif_rd_rsp_pd);
      check("cdt_pop",        clt_rd_cdt_lat_fifo_pop, e_rv & clt_rd_rsp_ready);
      check("rsp_err",        rsp_err, m_err);
      for (int k = 0; k < 3; k++) begin
         if (clt_rd_req_ready[k]) gnt_log.push_back(k);
         if (clt_rd_cdt_lat_fifo_pop[k]) cdt_cnt[k]++;
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         if (exp_q.size() == 0) begin
            if (mcif_rd_rsp_valid) m_err = 1;
         end else if (mcif_rd_rsp_valid && e_rsp_rdy) begin
            m_beats++;
            if (m_beats == int'(exp_q[0][14:0]) + 1) begin
               void'(exp_q.pop_front());
               m_beats = 0;
            end
         end
         if (w >= 0) begin
            exp_q.push_back({2'(w), clt_rd_req_pd[w][46:32]});
            m_rr     = (w + 1) % 3;
            m_out_v  = 1;
            m_out_pd = clt_rd_req_pd[w];
         end else if (mcif_rd_req_ready) begin
            m_out_v = 0;
         end
      end
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic set_idle();
      clt_rd_req_valid  = 3'b000;
      clt_rd_req_pd     = '0;
      mcif_rd_req_ready = 1'b1;
      mcif_rd_rsp_valid = 1'b0;
      mcif_rd_rsp_pd    = '0;
      clt_rd_rsp_ready  = 3'b000;
   endtask

   task automatic set_req(input int c, input int size);
      clt_rd_req_pd[c] = {15'(size), 32'($urandom())};
   endtask

   task automatic drain();
      clt_rd_req_valid  = 3'b000;
      mcif_rd_req_ready = 1'b1;
      clt_rd_rsp_ready  = 3'b111;
      for (int n = 0; n < 400 && exp_q.size() > 0; n++) begin
         mcif_rd_rsp_valid = 1'b1;
         mcif_rd_rsp_pd    = {1'($urandom()), 32'($urandom()), 32'($urandom())};
         cycle();
      end
      mcif_rd_rsp_valid = 1'b0;
      check("drain_left", exp_q.size(), 0);
      cycle();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      set_idle();
      for (int k = 0; k < 3; k++) cdt_cnt[k] = 0;

      // Reset: requests pending but nothing may be granted
      rst = 1'b1;
      clt_rd_req_valid = 3'b111;
      repeat (3) cycle();
      check("rst_req_valid", mcif_rd_req_valid, 1'b0);
      rst = 1'b0;
      clt_rd_req_valid = 3'b000;
      cycle();

      // Round-robin with all clients requesting continuously
      gnt_log.delete();
      clt_rd_req_valid = 3'b111;
      repeat (6) begin
         for (int k = 0; k < 3; k++) set_req(k, 0);
         cycle();
      end
      clt_rd_req_valid = 3'b000;
      check("rr_count", gnt_log.size(), 6);
      for (int i = 0; i < gnt_log.size() && i < 6; i++) check("rr_order", gnt_log[i], i % 3);
      drain();

      // Tag FIFO full: only DEPTH grants until a response completes
      gnt_log.delete();
      clt_rd_req_valid = 3'b001;
      set_req(0, 0);
      repeat (DEPTH + 4) cycle();
      check("full_grants", gnt_log.size(), DEPTH);
      clt_rd_rsp_ready  = 3'b111;
      mcif_rd_rsp_valid = 1'b1;
      cycle();
      check("full_no_same_cycle", gnt_log.size(), DEPTH);
      mcif_rd_rsp_valid = 1'b0;
      cycle();
      clt_rd_req_valid = 3'b000;
      check("full_after_pop", gnt_log.size(), DEPTH + 1);
      drain();

      // Multi-beat routing: client 1 size 3 then client 2 size 0
      clt_rd_req_valid = 3'b010; set_req(1, 3); cycle();
      clt_rd_req_valid = 3'b100; set_req(2, 0); cycle();
      clt_rd_req_valid = 3'b000;
      for (int k = 0; k < 3; k++) cdt_cnt[k] = 0;
      clt_rd_rsp_ready = 3'b111;
      for (int b = 0; b < 5; b++) begin
         mcif_rd_rsp_valid = 1'b1;
         mcif_rd_rsp_pd    = {1'b0, 32'($urandom()), 32'(b)};
         cycle();
      end
      mcif_rd_rsp_valid = 1'b0;
      check("cdt_client0", cdt_cnt[0], 0);
      check("cdt_client1", cdt_cnt[1], 4);
      check("cdt_client2", cdt_cnt[2], 1);
      check("multi_beat_done", exp_q.size(), 0);
      cycle();

      // MCIF backpressure: no grants while stalled, grant the cycle ready returns
      gnt_log.delete();
      clt_rd_req_valid  = 3'b001;
      set_req(0, 0);
      mcif_rd_req_ready = 1'b1;
      cycle();
      mcif_rd_req_ready = 1'b0;
      repeat (5) begin
         set_req(0, 0);
         cycle();
      end
      check("stall_grants", gnt_log.size(), 1);
      mcif_rd_req_ready = 1'b1;
      cycle();
      check("resume_grant", gnt_log.size(), 2);
      clt_rd_req_valid = 3'b000;
      drain();

      // Response with nothing outstanding
      clt_rd_rsp_ready  = 3'b000;
      mcif_rd_rsp_valid = 1'b1;
      cycle();
      mcif_rd_rsp_valid = 1'b0;
      repeat (3) cycle();
      check("rsp_err_sticky", rsp_err, 1'b1);

      // Reset with three tags outstanding, then first grant goes to client 0
      clt_rd_req_valid = 3'b111;
      for (int k = 0; k < 3; k++) set_req(k, 2);
      repeat (3) cycle();
      clt_rd_req_valid = 3'b000;
      cycle();
      rst = 1'b1;
      clt_rd_req_valid = 3'b111;
      repeat (2) cycle();
      check("rst_err_clear", rsp_err, 1'b0);
      rst = 1'b0;
      gnt_log.delete();
      cycle();
      clt_rd_req_valid = 3'b000;
      check("post_rst_grants", gnt_log.size(), 1);
      if (gnt_log.size() > 0) check("post_rst_client", gnt_log[0], 0);
      drain();

      // Random traffic with occasional reset
      for (int n = 0; n < 2000; n++) begin
         for (int k = 0; k < 3; k++) begin
            clt_rd_req_valid[k] = ($urandom_range(0, 2) == 0);
            set_req(k, $urandom_range(0, 3));
         end
         mcif_rd_req_ready = ($urandom_range(0, 3) != 0);
         mcif_rd_rsp_valid = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
         mcif_rd_rsp_pd    = {1'($urandom()), 32'($urandom()), 32'($urandom())};
         clt_rd_rsp_ready  = 3'($urandom_range(0, 7));
         rst               = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rst = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
